// File: rtl/vnlp_pkg.sv
// Shared widths, FSM encoding, node layout and the norm2 word-reduction helper
// for the linked-list vector norm engine.
package vnlp_pkg;

    localparam int WORD_SIZE   = 24;
    localparam int LEN_SIZE    = 8;
    localparam int MEMORY_SIZE = 512;
    localparam int STATE_SIZE  = 2;
    localparam int PRECIS      = 39;
    localparam int ADDR_W      = 9;
    localparam int MAG_W       = WORD_SIZE - 1;   // magnitude bits of a sign-magnitude word
    localparam int SQ_W        = 2 * MAG_W;       // exact square: 16 int | 30 frac
    localparam int SUM_W       = SQ_W + 2;        // headroom for acc + x^2 + y^2

    typedef enum logic [STATE_SIZE-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN_SIZE-1:0] NULL_PTR = '0;
    localparam logic [LEN_SIZE-1:0] LEN_MAX  = '1;

    // Word offsets of the fields inside one node.
    localparam logic [ADDR_W-1:0] OFF_NEXT = 9'd0;
    localparam logic [ADDR_W-1:0] OFF_TAG  = 9'd1;
    localparam logic [ADDR_W-1:0] OFF_X    = 9'd2;
    localparam logic [ADDR_W-1:0] OFF_Y    = 9'd3;

    localparam logic [WORD_SIZE-1:0] NORM2_SAT = {1'b0, {MAG_W{1'b1}}};

    // Reduce the 9.30 accumulator to a positive 8.15 sign-magnitude word.
    // Anything at or above 256.0, or a rounding carry out of the top, saturates.
    function automatic logic [WORD_SIZE-1:0] reduce_norm(
        input logic [PRECIS-1:0] acc,
        input logic              round_en
    );
        logic [WORD_SIZE-1:0] rounded;
        rounded = {1'b0, acc[PRECIS-2:15]} + {{(WORD_SIZE-1){1'b0}}, round_en & acc[14]};
        if (acc[PRECIS-1] || rounded[WORD_SIZE-1]) begin
            return NORM2_SAT;
        end
        return rounded;
    endfunction

endpackage

// File: rtl/vector_norm_list_proc_mem.sv
// Node memory: 512 x 24 words, filled from outside by hierarchical preload,
// with three asynchronous read ports (next pointer, x, y of the current node).
module vnlp_mem
    import vnlp_pkg::*;
(
    input  logic [ADDR_W-1:0]    addr_next_i,
    input  logic [ADDR_W-1:0]    addr_x_i,
    input  logic [ADDR_W-1:0]    addr_y_i,
    output logic [WORD_SIZE-1:0] data_next_o,
    output logic [WORD_SIZE-1:0] data_x_o,
    output logic [WORD_SIZE-1:0] data_y_o
);

    logic [WORD_SIZE-1:0] memory [MEMORY_SIZE];

    // All reads are combinational so one node is consumed per clock.
    assign data_next_o = memory[addr_next_i];
    assign data_x_o    = memory[addr_x_i];
    assign data_y_o    = memory[addr_y_i];

endmodule

// File: rtl/vector_norm_list_proc.sv
// Linked-list walker: from address 0, sums x^2 + y^2 over every node into a
// saturating 9.30 accumulator and counts nodes, one node per clock.
module vector_norm_list_proc
    import vnlp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  full_precis,
    output logic [LEN_SIZE-1:0]   i,
    output logic [LEN_SIZE-1:0]   len,
    output logic [PRECIS-1:0]     norm2_full,
    output logic [WORD_SIZE-1:0]  norm2,
    output logic [STATE_SIZE-1:0] the_state,
    output logic                  done
);

    state_t              state_q, state_d;
    logic [LEN_SIZE-1:0] i_q, i_d;
    logic [LEN_SIZE-1:0] len_q, len_d;
    logic [PRECIS-1:0]   acc_q, acc_d;

    logic [ADDR_W-1:0]    addr_next, addr_x, addr_y;
    logic [WORD_SIZE-1:0] word_next, word_x, word_y;
    logic [MAG_W-1:0]     mag_x, mag_y;
    logic [SQ_W-1:0]      sq_x, sq_y;
    logic [SUM_W-1:0]     sum_full;
    logic [PRECIS-1:0]    acc_sat;
    logic [LEN_SIZE-1:0]  next_ptr;
    logic                 unused_bits;

    assign addr_next = {1'b0, i_q} + OFF_NEXT;
    assign addr_x    = {1'b0, i_q} + OFF_X;
    assign addr_y    = {1'b0, i_q} + OFF_Y;

    vnlp_mem M2 (
        .addr_next_i (addr_next),
        .addr_x_i    (addr_x),
        .addr_y_i    (addr_y),
        .data_next_o (word_next),
        .data_x_o    (word_x),
        .data_y_o    (word_y)
    );

    // Sign bits drop out because squaring only needs magnitudes; the pointer
    // lives in the low byte of the NEXT word.
    assign next_ptr    = word_next[LEN_SIZE-1:0];
    assign mag_x       = word_x[MAG_W-1:0];
    assign mag_y       = word_y[MAG_W-1:0];
    assign unused_bits = ^{word_next[WORD_SIZE-1:LEN_SIZE], word_x[WORD_SIZE-1], word_y[WORD_SIZE-1]};

    // Exact squares and the saturating accumulate for the current node.
    always_comb begin
        sq_x     = {{MAG_W{1'b0}}, mag_x} * {{MAG_W{1'b0}}, mag_x};
        sq_y     = {{MAG_W{1'b0}}, mag_y} * {{MAG_W{1'b0}}, mag_y};
        sum_full = {2'b00, sq_x} + {2'b00, sq_y} + {{(SUM_W-PRECIS){1'b0}}, acc_q};
        if (|sum_full[SUM_W-1:PRECIS]) begin
            acc_sat = '1;
        end else begin
            acc_sat = sum_full[PRECIS-1:0];
        end
    end

    // State and datapath registers; reset clears every visible output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            len_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            len_q   <= len_d;
            acc_q   <= acc_sat_sel(state_q, state_d, acc_d);
        end
    end

    // Passthrough kept as a function so the register block stays a plain copy.
    function automatic logic [PRECIS-1:0] acc_sat_sel(
        input state_t              cur,
        input state_t              nxt,
        input logic [PRECIS-1:0]   val
    );
        logic unused_sel;
        unused_sel = (cur == nxt);
        return val;
    endfunction

    // Next-state logic: start launches a fresh walk from IDLE or DONE, RUN
    // consumes one node per cycle and stops on a null pointer or at len 255.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        len_d   = len_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    i_d     = NULL_PTR;
                    len_d   = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                acc_d = acc_sat;
                i_d   = next_ptr;
                if (len_q != LEN_MAX) begin
                    len_d = len_q + 1'b1;
                end
                if ((next_ptr == NULL_PTR) || (len_q >= LEN_MAX - 1'b1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign i          = i_q;
    assign len        = len_q;
    assign norm2_full = acc_q;
    assign norm2      = reduce_norm(acc_q, full_precis);
    assign the_state  = state_q;
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_vector_norm_list_proc.sv
// Directed bench for vector_norm_list_proc: expected len / norm2_full pushed
// on each start, popped and compared when done rises.
module tb_vector_norm_list_proc;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        full_precis;
    logic [7:0]  i;
    logic [7:0]  len;
    logic [38:0] norm2_full;
    logic [23:0] norm2;
    logic [1:0]  the_state;
    logic        done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  len;
        logic [38:0] full;
    } exp_t;

    exp_t        sb [$];
    logic [23:0] tb_mem [512];

    localparam logic [38:0] ALL39   = 39'h7F_FFFF_FFFF;
    localparam logic [23:0] SAT24   = 24'h7F_FFFF;

    vector_norm_list_proc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .full_precis (full_precis),
        .i           (i),
        .len         (len),
        .norm2_full  (norm2_full),
        .norm2       (norm2),
        .the_state   (the_state),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [23:0] v);
        tb_mem[a]           = v;
        dut.M2.memory[a]    = v;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 512; a++) wr(a, 24'h0);
    endtask

    // Reference walk of the list held in the shadow memory.
    function automatic exp_t model_walk();
        exp_t        r;
        int          p;
        logic [47:0] acc;
        logic [45:0] sx, sy;
        p   = 0;
        acc = 0;
        r.len = 0;
        forever begin
            sx  = 46'(tb_mem[p + 2][22:0]) * 46'(tb_mem[p + 2][22:0]);
            sy  = 46'(tb_mem[p + 3][22:0]) * 46'(tb_mem[p + 3][22:0]);
            acc = acc + 48'(sx) + 48'(sy);
            if (acc > 48'(ALL39)) acc = 48'(ALL39);
            r.len = r.len + 8'd1;
            if (tb_mem[p][7:0] == 8'd0 || r.len == 8'd255) break;
            p = int'(tb_mem[p][7:0]);
        end
        r.full = acc[38:0];
        return r;
    endfunction

    function automatic logic [23:0] model_norm2(input logic [38:0] a, input logic fp);
        int unsigned v;
        if (a >= (39'd256 << 30)) return SAT24;
        v = int'(a >> 15) + ((fp && a[14]) ? 1 : 0);
        if (v > 32'h7F_FFFF) return SAT24;
        return 24'(v);
    endfunction

    task automatic pulse_start(input int hold);
        @(posedge clk); #1;
        start = 1'b1;
        sb.push_back(model_walk());
        repeat (hold) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        exp_t e;
        cycles = 0;
        while (!done && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_len"}, 64'(len), 64'(e.len));
            check({tag, "_full"}, 64'(norm2_full), 64'(e.full));
            check({tag, "_norm2"}, 64'(norm2), 64'(model_norm2(e.full, full_precis)));
            $display("txn %s: len=%0d norm2_full=%0h norm2=%0h cycles=%0d", tag, len, norm2_full, norm2, cycles);
        end
    endtask

    initial begin
        int   cyc;
        logic [38:0] first_full;

        rst_n       = 1'b1;
        start       = 1'b0;
        full_precis = 1'b0;
        clear_mem();
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", 64'(the_state), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_len", 64'(len), 64'd0);
        check("rst_i", 64'(i), 64'd0);
        check("rst_full", 64'(norm2_full), 64'd0);
        @(posedge clk); #3 rst_n = 1'b1;

        // 1: three-node list, sum ~278.2 -> saturated word in both modes.
        wr(0, 24'd49);
        wr(2, 24'b1_00000110_100001001000000);
        wr(3, 24'b0_00000101_101111100000000);
        wr(49, 24'd39);
        wr(51, 24'b0_00000111_110010111111000);
        wr(52, 24'b0_00000110_111111010000000);
        wr(39, 24'd0);
        wr(41, 24'b0_00000110_111000100110000);
        wr(42, 24'b0_00000110_110000101010000);
        pulse_start(1);
        check("t1_run_state", 64'(the_state), 64'd1);
        wait_done("t1", 20, cyc);
        check("t1_cycles", 64'(cyc), 64'd3);
        check("t1_over256", 64'(norm2_full[38]), 64'd1);
        check("t1_sat_trunc", 64'(norm2), 64'(SAT24));
        full_precis = 1'b1; #1;
        check("t1_sat_round", 64'(norm2), 64'(SAT24));
        full_precis = 1'b0;
        first_full = norm2_full;

        // 6: restart from DONE, start held two cycles (second edge lands in RUN).
        pulse_start(2);
        wait_done("t6", 20, cyc);
        check("t6_same_full", 64'(norm2_full), 64'(first_full));
        check("t6_cycles", 64'(cyc), 64'd2);

        // 2: single node 3.0, -4.0 -> 25.0.
        clear_mem();
        wr(2, 24'b0_00000011_000000000000000);
        wr(3, 24'b1_00000100_000000000000000);
        pulse_start(1);
        wait_done("t2", 20, cyc);
        check("t2_full", 64'(norm2_full), 64'd25 << 30);
        check("t2_norm2", 64'(norm2), 64'(24'b0_00011001_000000000000000));

        // 3: x = 2^-15 -> acc = 2^-30, rounds to 0 either way.
        clear_mem();
        wr(2, 24'h000001);
        pulse_start(1);
        wait_done("t3", 20, cyc);
        check("t3_full", 64'(norm2_full), 64'd1);
        check("t3_trunc", 64'(norm2), 64'd0);
        full_precis = 1'b1; #1;
        check("t3_round", 64'(norm2), 64'd0);
        full_precis = 1'b0;

        // 3b: x = 2^-8 -> acc bit 14 set, rounding lifts the LSB in DONE.
        clear_mem();
        wr(2, 24'h000080);
        pulse_start(1);
        wait_done("t3b", 20, cyc);
        check("t3b_full", 64'(norm2_full), 64'd1 << 14);
        check("t3b_trunc", 64'(norm2), 64'd0);
        full_precis = 1'b1; #1;
        check("t3b_round", 64'(norm2), 64'd1);
        full_precis = 1'b0; #1;
        check("t3b_trunc_again", 64'(norm2), 64'd0);

        // 5: largest magnitudes -> accumulator saturates.
        clear_mem();
        wr(2, 24'h7FFFFF);
        wr(3, 24'hFFFFFF);
        pulse_start(1);
        wait_done("t5", 20, cyc);
        check("t5_full_sat", 64'(norm2_full), 64'(ALL39));
        check("t5_norm2_sat", 64'(norm2), 64'(SAT24));

        // Endless list (node 4 points to itself) stops at len 255.
        clear_mem();
        wr(0, 24'd4);
        wr(4, 24'd4);
        wr(6, 24'b0_00000001_000000000000000);
        pulse_start(1);
        wait_done("loop", 400, cyc);
        check("loop_len", 64'(len), 64'd255);
        check("loop_full", 64'(norm2_full), 64'd254 << 30);
        check("loop_norm2", 64'(norm2), 64'(24'b0_11111110_000000000000000));

        // 4: asynchronous reset in the middle of a run.
        pulse_start(1);
        @(posedge clk); #3;
        check("t4_pre_state", 64'(the_state), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t4_state", 64'(the_state), 64'd0);
        check("t4_done", 64'(done), 64'd0);
        check("t4_len", 64'(len), 64'd0);
        check("t4_i", 64'(i), 64'd0);
        check("t4_full", 64'(norm2_full), 64'd0);
        sb.delete();
        @(posedge clk); #3 rst_n = 1'b1;
        pulse_start(1);
        wait_done("t4_after", 400, cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
